// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: load/store funct3 values and FSM states.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the memory stage: store enables/replication, load
// extraction with sign/zero extension, and the access legality check.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        legal
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        aligned_s;
  logic [31:0] rep_s;

  // Lane decode by access size, then extension by funct3.
  always_comb begin
    byte_s    = 8'h00;
    half_s    = 16'h0000;
    aligned_s = 1'b0;
    rep_s     = 32'h0000_0000;
    be        = 4'b0000;
    wdata     = 32'h0000_0000;
    load_data = 32'h0000_0000;
    legal     = 1'b0;

    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (func3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        aligned_s = 1'b1;
        rep_s     = {4{store_data[7:0]}};
      end
      2'b01: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        aligned_s = ~addr_lo[0];
        rep_s     = {2{store_data[15:0]}};
      end
      2'b10: begin
        be        = 4'b1111;
        aligned_s = (addr_lo == 2'b00);
        rep_s     = store_data;
      end
      default: begin
        be        = 4'b0000;
        aligned_s = 1'b0;
        rep_s     = 32'h0000_0000;
      end
    endcase

    if (is_store) begin
      legal = aligned_s & ((func3 == F3_SB) | (func3 == F3_SH) | (func3 == F3_SW));
      wdata = rep_s;
    end else begin
      legal = aligned_s & ((func3 == F3_LB) | (func3 == F3_LH) | (func3 == F3_LW) |
                           (func3 == F3_LBU) | (func3 == F3_LHU));
      wdata = 32'h0000_0000;
    end

    case (func3)
      F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      F3_LH:   load_data = {{16{half_s[15]}}, half_s};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'h00_0000, byte_s};
      F3_LHU:  load_data = {16'h0000, half_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: ALU results pass through in one cycle; loads/stores
// run a req/gnt/rvalid transaction while stalling everything upstream.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_we_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      mem_func3_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic            misalign_o
);

  state_e            state_r, state_nxt_s;
  logic [XLEN-1:0]   cap_addr_r;
  logic [2:0]        cap_func3_r;
  logic [4:0]        cap_rd_addr_r;
  logic              cap_rd_we_r;
  logic              cap_store_r;
  logic [3:0]        cap_be_r;
  logic [XLEN-1:0]   cap_wdata_r;

  logic [4:0]        rd_addr_r, rd_addr_nxt_s;
  logic [XLEN-1:0]   rd_data_r, rd_data_nxt_s;
  logic              rd_we_r, rd_we_nxt_s;
  logic              misalign_r, misalign_nxt_s;

  logic              in_idle_s, memop_s, stall_s, capture_s, req_s;
  logic [2:0]        al_func3_s;
  logic [1:0]        al_addr_s;
  logic              al_store_s;
  logic [3:0]        al_be_s;
  logic [31:0]       al_wdata_s, al_load_s;
  logic              al_legal_s;

  // The aligner sees live inputs while idle (legality, lanes) and the
  // captured operation afterwards (load extraction).
  assign in_idle_s  = (state_r == ST_IDLE);
  assign memop_s    = mem_re_i | mem_we_i;
  assign al_func3_s = in_idle_s ? mem_func3_i    : cap_func3_r;
  assign al_addr_s  = in_idle_s ? rd_data_i[1:0] : cap_addr_r[1:0];
  assign al_store_s = in_idle_s ? mem_we_i       : cap_store_r;

  lsu_align u_lsu_align (
    .func3      (al_func3_s),
    .addr_lo    (al_addr_s),
    .is_store   (al_store_s),
    .store_data (store_data_i),
    .rdata      (dmem_rdata_i),
    .be         (al_be_s),
    .wdata      (al_wdata_s),
    .load_data  (al_load_s),
    .legal      (al_legal_s)
  );

  // Next-state, stall and next output values.
  always_comb begin
    state_nxt_s    = state_r;
    stall_s        = 1'b0;
    capture_s      = 1'b0;
    misalign_nxt_s = 1'b0;
    rd_addr_nxt_s  = rd_addr_r;
    rd_data_nxt_s  = rd_data_r;
    rd_we_nxt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (valid_i && memop_s) begin
          if (al_legal_s) begin
            state_nxt_s = ST_REQ;
            stall_s     = 1'b1;
            capture_s   = 1'b1;
          end else begin
            misalign_nxt_s = 1'b1;
          end
        end else if (valid_i) begin
          rd_addr_nxt_s = rd_addr_i;
          rd_data_nxt_s = rd_data_i;
          rd_we_nxt_s   = rd_we_i;
        end else begin
          rd_we_nxt_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          if (cap_store_r) begin
            state_nxt_s = ST_IDLE;
            stall_s     = 1'b0;
          end else begin
            state_nxt_s = ST_RESP;
            stall_s     = 1'b1;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (dmem_rvalid_i) begin
          state_nxt_s   = ST_IDLE;
          rd_addr_nxt_s = cap_rd_addr_r;
          rd_data_nxt_s = al_load_s;
          rd_we_nxt_s   = cap_rd_we_r;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        stall_s     = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Captured operation; holds the bus request stable until granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_addr_r    <= {XLEN{1'b0}};
      cap_func3_r   <= 3'b000;
      cap_rd_addr_r <= 5'd0;
      cap_rd_we_r   <= 1'b0;
      cap_store_r   <= 1'b0;
      cap_be_r      <= 4'b0000;
      cap_wdata_r   <= {XLEN{1'b0}};
    end else if (capture_s) begin
      cap_addr_r    <= rd_data_i;
      cap_func3_r   <= mem_func3_i;
      cap_rd_addr_r <= rd_addr_i;
      cap_rd_we_r   <= rd_we_i;
      cap_store_r   <= mem_we_i;
      cap_be_r      <= al_be_s;
      cap_wdata_r   <= al_wdata_s;
    end
  end

  // Writeback/forwarding and misalign output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_r  <= 5'd0;
      rd_data_r  <= {XLEN{1'b0}};
      rd_we_r    <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      rd_addr_r  <= rd_addr_nxt_s;
      rd_data_r  <= rd_data_nxt_s;
      rd_we_r    <= rd_we_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

  assign req_s        = (state_r == ST_REQ);
  assign stall_o      = stall_s;
  assign dmem_req_o   = req_s;
  assign dmem_we_o    = req_s & cap_store_r;
  assign dmem_addr_o  = {cap_addr_r[XLEN-1:2], 2'b00};
  assign dmem_be_o    = cap_be_r;
  assign dmem_wdata_o = cap_wdata_r;
  assign rd_addr_o    = rd_addr_r;
  assign rd_data_o    = rd_data_r;
  assign rd_we_o      = rd_we_r;
  assign misalign_o   = misalign_r;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the five-stage forwarding pipeline. Sits directly downstream of the execute stage and upstream of writeback.
- Non-memory results pass through in one registered cycle.
- Loads and stores run a req/gnt/rvalid transaction on the data-memory port. The stage stalls the upstream pipeline until the transaction completes.
- Drives the rd_addr/rd_data/rd_we triple consumed by writeback and the forwarding unit.

Parameters:
XLEN, 32, datapath width; only 32 is supported (byte lanes are 4).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
valid_i  in  1  execute-stage output holds a live instruction
rd_addr_i  in  5  destination register
rd_data_i  in  XLEN  ALU result; effective address for loads/stores
rd_we_i  in  1  register write enable
mem_re_i  in  1  instruction is a load
mem_we_i  in  1  instruction is a store
mem_func3_i  in  3  load/store funct3
store_data_i  in  XLEN  rs2 value for stores
stall_o  out  1  hold execute stage and everything upstream
dmem_req_o  out  1  memory request
dmem_we_o  out  1  request is a write
dmem_addr_o  out  XLEN  word-aligned address
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  XLEN  read data
rd_addr_o  out  5  to writeback/forwarding
rd_data_o  out  XLEN  to writeback/forwarding
rd_we_o  out  1  to writeback/forwarding
misalign_o  out  1  one-cycle pulse: misaligned or illegal access dropped

Behaviour:
- Reset (rst_ni low, async):
  - state=IDLE.
  - All registered outputs 0; dmem_req_o=0.
  - Captured operation registers cleared.
- FSM states: IDLE, REQ, RESP.
- IDLE, no memop (valid_i & !(mem_re_i|mem_we_i)):
  - Next edge: rd_*_o <= rd_*_i.
  - stall_o=0; latency 1.
- IDLE, !valid_i: rd_we_o <= 0 (bubble).
- IDLE, valid memop:
  - Legality check first. LB/LBU/SB are always aligned. LH/LHU/SH need addr[0]=0. LW/SW need addr[1:0]=0. func3 must be 000/001/010/100/101 for loads and 000/001/010 for stores.
  - Illegal or misaligned: no bus request, misalign_o <= 1, rd_we_o <= 0, stall_o=0, stay IDLE.
  - Legal: capture address, func3, rd_addr, rd_we, load/store flag, be and wdata. Then go to REQ. stall_o=1, rd_we_o <= 0.
- REQ:
  - dmem_req_o=1, driven from captured registers only. dmem_addr_o={addr[31:2],2'b00}.
  - Request fields stay stable until dmem_gnt_i.
  - Store with gnt: go to IDLE, stall_o=0 this cycle, rd_we_o <= 0.
  - Load with gnt: go to RESP, stall_o=1.
  - No gnt: stay in REQ, stall_o=1.
- RESP:
  - dmem_req_o=0.
  - On dmem_rvalid_i: rd_data_o <= extended lane data, rd_addr_o/rd_we_o <= captured values, go to IDLE, stall_o=0 this cycle.
  - Otherwise stall_o=1.
- stall_o is combinational:
  - IDLE: valid_i & memop & legal.
  - REQ: !(store & gnt).
  - RESP: !rvalid.
- The instruction is consumed on the edge where stall_o=0. Execute holds its outputs while stall_o=1, and this stage ignores them outside IDLE.
- Minimum latency: store 2 cycles, load 3 cycles.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW: be=4'hF, wdata=data.
  - Loads drive be per size the same way; dmem_wdata_o=0 for loads.
- Load extraction:
  - Byte select by addr[1:0]; halfword select by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Ignored inputs: dmem_rvalid_i in IDLE/REQ, and dmem_gnt_i outside REQ.
- Reset mid-transaction aborts the transaction and drops dmem_req_o immediately. A late rvalid after reset is ignored.
- misalign_o is high for exactly one cycle per dropped access.

Decomposition:
- Add to defines.v:
  - funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state encodings (2 bits).
- One combinational sub-module, lsu_align. Inputs: func3, addr[1:0], store data, read data. Outputs: be, replicated wdata, extended load data, legal flag.
- mem_stage owns the FSM, the capture registers and the output registers.

Test Plan:
- ALU pass-through: valid, rd=5, data=0x1234, we=1, no memop -> next cycle rd_addr_o=5, rd_data_o=0x00001234, rd_we_o=1; stall_o never high.
- SB addr 0x103, data 0xAB, gnt on first REQ cycle -> dmem_addr_o=0x100, be=4'b1000, wdata=0xABABABAB; stall_o high 1 cycle; rd_we_o=0.
- LH addr 0x202, rdata 0x80017FFF, gnt after 2 wait cycles, rvalid after 3 -> rd_data_o=0xFFFF8001; LHU gives 0x00008001; stall_o released on the rvalid cycle only.
- LW addr 0x301 -> no dmem_req_o, misalign_o pulses 1 cycle, rd_we_o=0, stall_o=0.
- Back-to-back LW(rd=3) then ADD(rd=4): ADD appears at rd_*_o exactly 1 cycle after the load result, and the load is not re-issued.
- Assert rst_ni low while in RESP -> dmem_req_o/rd_we_o go 0 asynchronously; a subsequent rvalid=1 produces no write.
